// File: rtl/aexm_dwb_pkg.sv
// Shared types for the aexm data-side write buffer: FSM states, buffer
// entry layout, legal byte-lane encodings and a lane-coverage helper.
package aexm_dwb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } dwbState_t;

  typedef enum logic [3:0] {
    SEL_B0   = 4'h1,
    SEL_B1   = 4'h2,
    SEL_B2   = 4'h4,
    SEL_B3   = 4'h8,
    SEL_HLO  = 4'h3,
    SEL_HHI  = 4'hC,
    SEL_WORD = 4'hF
  } dwbSel_t;

  typedef struct packed {
    logic [29:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } sbuf_entry_t;

  // True when every lane the load wants was written by the entry.
  function automatic logic selCovers(input logic [3:0] entrySel, input logic [3:0] loadSel);
    return (loadSel & ~entrySel) == 4'h0;
  endfunction

endpackage

// File: rtl/aexm_sbuf_fifo.sv
// Circular store buffer with per-entry valid bits and an address CAM.
// Optional feature macro: AEXM_DWB_SBUF_FWD_EN adds a newest-hit data port.
module aexm_sbuf_fifo
  import aexm_dwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        push,
  input  sbuf_entry_t pushEntry,
  input  logic        pop,
  input  logic [29:0] matchAdr,
  output sbuf_entry_t headEntry,
  output logic        full,
  output logic        empty,
  output logic        anyHit
`ifdef AEXM_DWB_SBUF_FWD_EN
  ,
  output logic        fwdHit,
  output sbuf_entry_t fwdEntry
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sbuf_entry_t      mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign doPush    = push & ~full;
  assign doPop     = pop & ~empty;
  assign headEntry = mem[rdPtr];

  // Pointer, occupancy and valid-bit bookkeeping; reset discards queued stores.
  always_ff @(posedge gclk) begin
    if (grst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (doPush) begin
        valid[wrPtr] <= 1'b1;
        wrPtr        <= wrPtr + PW'(1);
      end
      if (doPop) begin
        valid[rdPtr] <= 1'b0;
        rdPtr        <= rdPtr + PW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset because valid bits qualify every read.
  always_ff @(posedge gclk) begin
    if (doPush) begin
      mem[wrPtr] <= pushEntry;
    end
  end

  // Any valid entry (including the one on the bus) at the load's word address.
  always_comb begin
    anyHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].adr == matchAdr)) begin
        anyHit = 1'b1;
      end
    end
  end

`ifdef AEXM_DWB_SBUF_FWD_EN
  // Walk oldest to newest so the last match left standing is the newest store.
  always_comb begin
    logic [PW-1:0] idx;
    fwdHit   = 1'b0;
    fwdEntry = '0;
    idx      = rdPtr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PW'(k);
      if (valid[idx] && (mem[idx].adr == matchAdr)) begin
        fwdHit   = 1'b1;
        fwdEntry = mem[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/aexm_dwb_sbuf.sv
// Data-side bus front end: store buffer drain, load bypass, hazard stall.
// Optional feature macro: AEXM_DWB_SBUF_FWD_EN forwards fully covered
// hazarding loads straight from the newest matching buffer entry.
module aexm_dwb_sbuf
  import aexm_dwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        rMEMOP_LD,
  input  logic        rMEMOP_ST,
  input  logic [31:0] rADDR,
  input  logic [3:0]  rDWBSEL,
  input  logic [31:0] aexm_dcache_datao,
  output logic [31:0] aexm_dcache_datai,
  output logic        dstall,
  output logic        sbuf_empty,
  output logic        dwb_stb_o,
  output logic        dwb_we_o,
  output logic [29:0] dwb_adr_o,
  output logic [3:0]  dwb_sel_o,
  output logic [31:0] dwb_dat_o,
  input  logic        dwb_ack_i,
  input  logic [31:0] dwb_dat_i
);

  dwbState_t   state;
  logic        ldDone;
  logic        ldPending;
  logic        fifoFull;
  logic        fifoEmpty;
  logic        anyHit;
  logic        push;
  logic        pop;
  logic        busDone;
  sbuf_entry_t pushEntry;
  sbuf_entry_t headEntry;
  logic        unusedAdrBits;

  assign unusedAdrBits = ^rADDR[1:0];
  assign pushEntry     = '{adr: rADDR[31:2], sel: rDWBSEL, dat: aexm_dcache_datao};
  assign ldPending     = rMEMOP_LD & ~ldDone;
  assign dstall        = ldPending | (rMEMOP_ST & fifoFull);
  assign push          = rMEMOP_ST & ~dstall;
  assign busDone       = dwb_stb_o & dwb_ack_i;
  assign pop           = (state == WR) & busDone;
  assign sbuf_empty    = fifoEmpty & (state != WR);

`ifdef AEXM_DWB_SBUF_FWD_EN
  logic        fwdHit;
  logic        fwdOk;
  sbuf_entry_t fwdEntry;
  assign fwdOk = ldPending & anyHit & fwdHit & selCovers(fwdEntry.sel, rDWBSEL);
`endif

  aexm_sbuf_fifo #(.DEPTH(DEPTH)) uFifo (
    .gclk      (gclk),
    .grst      (grst),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .matchAdr  (rADDR[31:2]),
    .headEntry (headEntry),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .anyHit    (anyHit)
`ifdef AEXM_DWB_SBUF_FWD_EN
    ,
    .fwdHit    (fwdHit),
    .fwdEntry  (fwdEntry)
`endif
  );

  // Bus FSM: loads beat the drain, every transfer returns to IDLE so the
  // strobe is low for at least one cycle between transfers.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state             <= IDLE;
      dwb_stb_o         <= 1'b0;
      dwb_we_o          <= 1'b0;
      dwb_adr_o         <= '0;
      dwb_sel_o         <= '0;
      dwb_dat_o         <= '0;
      aexm_dcache_datai <= '0;
      ldDone            <= 1'b0;
    end else begin
      ldDone <= 1'b0;
      case (state)
        IDLE: begin
`ifdef AEXM_DWB_SBUF_FWD_EN
          if (fwdOk) begin
            aexm_dcache_datai <= fwdEntry.dat;
            ldDone            <= 1'b1;
          end else
`endif
          if (ldPending && !anyHit) begin
            state     <= RD;
            dwb_stb_o <= 1'b1;
            dwb_we_o  <= 1'b0;
            dwb_adr_o <= rADDR[31:2];
            dwb_sel_o <= rDWBSEL;
          end else if (!fifoEmpty) begin
            state     <= WR;
            dwb_stb_o <= 1'b1;
            dwb_we_o  <= 1'b1;
            dwb_adr_o <= headEntry.adr;
            dwb_sel_o <= headEntry.sel;
            dwb_dat_o <= headEntry.dat;
          end
        end
        WR: begin
          if (busDone) begin
            state     <= IDLE;
            dwb_stb_o <= 1'b0;
            dwb_we_o  <= 1'b0;
          end
        end
        RD: begin
          if (busDone) begin
            state             <= IDLE;
            dwb_stb_o         <= 1'b0;
            aexm_dcache_datai <= dwb_dat_i;
            ldDone            <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          dwb_stb_o <= 1'b0;
          dwb_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aexm_dwb_sbuf.sv
// Scoreboard bench for aexm_dwb_sbuf: directed scenarios plus random
// load/store traffic against a word-level memory model and a random-latency
// bus slave. Builds with or without AEXM_DWB_SBUF_FWD_EN.
module tb_aexm_dwb_sbuf;
  import aexm_dwb_pkg::*;

  localparam int DEPTH = 4;

  logic        gclk = 1'b0;
  logic        grst;
  logic        rMEMOP_LD;
  logic        rMEMOP_ST;
  logic [31:0] rADDR;
  logic [3:0]  rDWBSEL;
  logic [31:0] aexm_dcache_datao;
  logic [31:0] aexm_dcache_datai;
  logic        dstall;
  logic        sbuf_empty;
  logic        dwb_stb_o;
  logic        dwb_we_o;
  logic [29:0] dwb_adr_o;
  logic [3:0]  dwb_sel_o;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_i;
  logic [31:0] dwb_dat_i;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  sel;
  } expLoad_t;

  int          nVectors = 0;
  int          nMiscompares = 0;
  sbuf_entry_t expWrites[$];
  expLoad_t    expLoads[$];
  logic [31:0] busMem [logic [29:0]];
  logic [31:0] archMem [logic [29:0]];
  int          ackMode = 1;
  bit          forceAck = 1'b0;
  int          writesDone = 0;
  int          readsDone = 0;
  int          rdWritesSeen = 0;
  logic [29:0] curLoadAdr = '0;
  logic [3:0]  curLoadSel = '0;

  aexm_dwb_sbuf #(.DEPTH(DEPTH)) dut (
    .gclk              (gclk),
    .grst              (grst),
    .rMEMOP_LD         (rMEMOP_LD),
    .rMEMOP_ST         (rMEMOP_ST),
    .rADDR             (rADDR),
    .rDWBSEL           (rDWBSEL),
    .aexm_dcache_datao (aexm_dcache_datao),
    .aexm_dcache_datai (aexm_dcache_datai),
    .dstall            (dstall),
    .sbuf_empty        (sbuf_empty),
    .dwb_stb_o         (dwb_stb_o),
    .dwb_we_o          (dwb_we_o),
    .dwb_adr_o         (dwb_adr_o),
    .dwb_sel_o         (dwb_sel_o),
    .dwb_dat_o         (dwb_dat_o),
    .dwb_ack_i         (dwb_ack_i),
    .dwb_dat_i         (dwb_dat_i)
  );

  always #5 gclk = ~gclk;

  // Memory contents before anything has been written.
  function automatic logic [31:0] initWord(input logic [29:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] laneMask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    return (old & ~laneMask(sel)) | (nw & laneMask(sel));
  endfunction

  function automatic logic [31:0] readBus(input logic [29:0] a);
    if (busMem.exists(a)) return busMem[a];
    return initWord(a);
  endfunction

  function automatic logic [31:0] readArch(input logic [29:0] a);
    if (archMem.exists(a)) return archMem[a];
    return initWord(a);
  endfunction

  function automatic logic [3:0] pickSel();
    case ($urandom_range(0, 6))
      0:       return 4'h1;
      1:       return 4'h2;
      2:       return 4'h4;
      3:       return 4'h8;
      4:       return 4'h3;
      5:       return 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] d, input logic [3:0] sel);
    case (sel)
      4'h1, 4'h2, 4'h4, 4'h8: return {4{d[7:0]}};
      4'h3, 4'hC:             return {2{d[15:0]}};
      default:                return d;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL %s: actual timeout, required completion within bound", name);
  endtask

  task automatic waitCycle();
    @(negedge gclk);
    #1;
  endtask

  task automatic waitEmpty();
    int n = 0;
    while (!(sbuf_empty && expWrites.size() == 0) && n < 1000) begin
      waitCycle();
      n++;
    end
    if (!(sbuf_empty && expWrites.size() == 0)) reportTimeout("waitEmpty");
  endtask

  // Present a store and hold it until accepted; returns at the next negedge+1.
  task automatic applyStore(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] dat,
                            output int stallCycles);
    rMEMOP_ST         = 1'b1;
    rADDR             = addr;
    rDWBSEL           = sel;
    aexm_dcache_datao = dat;
    stallCycles       = 0;
    #1;
    while (dstall && stallCycles < 200) begin
      stallCycles++;
      waitCycle();
    end
    if (dstall) begin
      reportTimeout("storeAccept");
      rMEMOP_ST = 1'b0;
    end else begin
      expWrites.push_back('{adr: addr[31:2], sel: sel, dat: dat});
      archMem[addr[31:2]] = mergeWord(readArch(addr[31:2]), dat, sel);
      @(posedge gclk);
      waitCycle();
      rMEMOP_ST = 1'b0;
    end
  endtask

  // Present a load and hold it until dstall drops; leaves one idle cycle after.
  task automatic applyLoad(input logic [31:0] addr, input logic [3:0] sel, output int stallCycles);
    expLoad_t e;
    e.data      = readArch(addr[31:2]);
    e.sel       = sel;
    expLoads.push_back(e);
    curLoadAdr  = addr[31:2];
    curLoadSel  = sel;
    rMEMOP_LD   = 1'b1;
    rADDR       = addr;
    rDWBSEL     = sel;
    stallCycles = 0;
    #1;
    while (dstall && stallCycles < 300) begin
      stallCycles++;
      waitCycle();
    end
    if (dstall) reportTimeout("loadComplete");
    rMEMOP_LD = 1'b0;
    waitCycle();
  endtask

  // Random mix of stores, loads and idle cycles over a small set of words.
  task automatic applyStimulus(input int nOps);
    int          r;
    int          s;
    logic [3:0]  sel;
    logic [31:0] addr;
    for (int i = 0; i < nOps; i++) begin
      r    = $urandom_range(0, 9);
      addr = {20'h0, 10'h100 + 10'($urandom_range(0, 7)), 2'b00};
      sel  = pickSel();
      if (r < 5) applyStore(addr, sel, replicate($urandom, sel), s);
      else if (r < 8) applyLoad(addr, sel, s);
      else waitCycle();
    end
  endtask

  // Bus slave and bus-protocol monitor; write transfers are popped from the
  // scoreboard and read transfers are checked for address and hazard order.
  initial begin
    logic        prevStb = 1'b0;
    logic        prevAck = 1'b0;
    logic        newAck;
    logic [66:0] prevBus = '0;
    logic [66:0] curBus;
    sbuf_entry_t e;
    int          hits;
    dwb_ack_i = 1'b0;
    dwb_dat_i = '0;
    forever begin
      @(negedge gclk);
      curBus = {dwb_we_o, dwb_adr_o, dwb_sel_o, dwb_dat_o};
      if (!grst && prevStb) begin
        if (prevAck) checkOutput("stbDropOnAck", dwb_stb_o, 1'b0);
        else checkOutput("busHeld", {dwb_stb_o, curBus}, {1'b1, prevBus});
      end
      prevStb = dwb_stb_o;
      prevBus = curBus;
      if (grst) newAck = 1'b0;
      else if (forceAck) newAck = 1'b1;
      else if (dwb_stb_o) newAck = (ackMode == 1) || (ackMode == 2 && $urandom_range(0, 2) != 0);
      else newAck = (ackMode == 2) && ($urandom_range(0, 7) == 0);
      dwb_dat_i = $urandom;
      if (newAck && dwb_stb_o && !grst) begin
        if (dwb_we_o) begin
          if (expWrites.size() == 0) begin
            reportTimeout("unexpectedWrite");
          end else begin
            e = expWrites.pop_front();
            checkOutput("busWrite", {dwb_adr_o, dwb_sel_o, dwb_dat_o}, {e.adr, e.sel, e.dat});
            busMem[e.adr] = mergeWord(readBus(e.adr), e.dat, e.sel);
          end
          writesDone++;
        end else begin
          hits = 0;
          foreach (expWrites[k]) if (expWrites[k].adr == dwb_adr_o) hits++;
          checkOutput("readHazard", hits, 0);
          checkOutput("readReq", {dwb_adr_o, dwb_sel_o}, {curLoadAdr, curLoadSel});
          dwb_dat_i    = readBus(dwb_adr_o);
          readsDone++;
          rdWritesSeen = writesDone;
        end
      end
      dwb_ack_i = newAck;
      prevAck   = newAck;
    end
  end

  // Load-completion monitor: compares only the lanes the load asked for.
  initial begin
    expLoad_t e;
    forever begin
      @(negedge gclk);
      if (!grst && rMEMOP_LD && !dstall) begin
        if (expLoads.size() == 0) begin
          reportTimeout("unexpectedLoadDone");
        end else begin
          e = expLoads.pop_front();
          checkOutput("loadData", aexm_dcache_datai & laneMask(e.sel), e.data & laneMask(e.sel));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: actual still running, required finished");
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int s5;
    int rdBefore;
    int wrBefore;
    grst              = 1'b1;
    rMEMOP_LD         = 1'b0;
    rMEMOP_ST         = 1'b0;
    rADDR             = '0;
    rDWBSEL           = '0;
    aexm_dcache_datao = '0;
    repeat (3) @(negedge gclk);
    checkOutput("resetBus", {dwb_stb_o, dwb_we_o, dwb_adr_o, dwb_sel_o, dwb_dat_o}, '0);
    checkOutput("resetData", aexm_dcache_datai, 32'h0);
    checkOutput("resetStall", dstall, 1'b0);
    checkOutput("resetEmpty", sbuf_empty, 1'b1);
    #1 grst = 1'b0;
    waitCycle();

    $display("[TB] single store");
    ackMode = 1;
    applyStore(32'h0000_0100, 4'hF, 32'hDEAD_BEEF, s);
    checkOutput("storeNoStall", s, 0);
    @(negedge gclk);
    checkOutput("storeStrobe", {dwb_stb_o, dwb_we_o, dwb_adr_o, dwb_sel_o, dwb_dat_o},
                {1'b1, 1'b1, 30'h40, 4'hF, 32'hDEAD_BEEF});
    @(negedge gclk);
    checkOutput("emptyAfterStore", sbuf_empty, 1'b1);
    #1;
    waitEmpty();

    $display("[TB] buffer full");
    ackMode = 0;
    for (int i = 0; i < 4; i++) begin
      applyStore(32'h0000_0700 + 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i), s);
      checkOutput("fillNoStall", s, 0);
    end
    fork
      applyStore(32'h0000_0710, 4'hF, 32'hC0DE_0004, s5);
      begin
        repeat (4) @(negedge gclk);
        #2 ackMode = 1;
      end
    join
    checkOutput("fullStall", (s5 >= 4), 1'b1);
    waitEmpty();

    $display("[TB] load bypass");
    busMem[30'h100]  = 32'h1234_5678;
    archMem[30'h100] = 32'h1234_5678;
    wrBefore = writesDone;
    for (int i = 0; i < 3; i++) applyStore(32'h0000_0200 + 32'(4 * i), 4'hF, 32'h2000_0000 + 32'(i), s);
    applyLoad(32'h0000_0400, 4'hF, s);
    checkOutput("bypassOrder", rdWritesSeen - wrBefore, 1);
    checkOutput("bypassStall", s, 2);
    checkOutput("bypassData", aexm_dcache_datai, 32'h1234_5678);
    waitEmpty();

    $display("[TB] load hazard");
    rdBefore = readsDone;
    applyStore(32'h0000_0300, 4'hF, 32'hAABB_CCDD, s);
    applyLoad(32'h0000_0300, 4'hF, s);
`ifdef AEXM_DWB_SBUF_FWD_EN
    checkOutput("fwdNoRead", readsDone - rdBefore, 0);
    checkOutput("fwdStall", s, 1);
`else
    checkOutput("hazardRead", readsDone - rdBefore, 1);
`endif
    checkOutput("hazardData", aexm_dcache_datai, 32'hAABB_CCDD);
    waitEmpty();

    $display("[TB] partial forward");
    rdBefore = readsDone;
    applyStore(32'h0000_0500, 4'h1, 32'h5A5A_5A5A, s);
    applyLoad(32'h0000_0500, 4'hF, s);
    checkOutput("partialRead", readsDone - rdBefore, 1);
    waitEmpty();

    $display("[TB] reset mid-operation");
    ackMode = 0;
    applyStore(32'h0000_0600, 4'hF, 32'h6000_0000, s);
    applyStore(32'h0000_0604, 4'hF, 32'h6000_0004, s);
    checkOutput("wrBeforeReset", {dwb_stb_o, dwb_we_o}, 2'b11);
    grst = 1'b1;
    @(negedge gclk);
    checkOutput("rstStb", dwb_stb_o, 1'b0);
    checkOutput("rstEmpty", sbuf_empty, 1'b1);
    checkOutput("rstStall", dstall, 1'b0);
    expWrites.delete();
    archMem.delete();
    foreach (busMem[k]) archMem[k] = busMem[k];
    #1 grst = 1'b0;
    forceAck = 1'b1;
    waitCycle();
    forceAck = 1'b0;
    @(negedge gclk);
    checkOutput("lateAckIgnored", {dwb_stb_o, sbuf_empty}, 2'b01);
    #1;

    $display("[TB] random traffic");
    ackMode = 2;
    applyStimulus(400);
    waitEmpty();
    checkOutput("writesDrained", expWrites.size(), 0);
    checkOutput("loadsDone", expLoads.size(), 0);
    checkOutput("finalEmpty", sbuf_empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/aexm_dwb_sbuf.md
# aexm_dwb_sbuf

Data-side bus front end for the aexm core. It sits directly below the register file and store sizer. Stores arrive as lane-replicated `aexm_dcache_datao` with a byte-lane select, go into a small write buffer, and drain to the data bus in order. Loads go to the bus, taking priority over the drain, and the fetched word returns on `aexm_dcache_datai` for the register file's load sizer. The block stalls the core whenever it cannot accept or complete a request.

## Interface
- `DEPTH`, default 4: store-buffer entries; power of two, 2..8.
- `gclk`  in  1  core clock; all state on the rising edge.
- `grst`  in  1  synchronous, active-high reset.
- `rMEMOP_LD`  in  1  load request; held stable by the core while `dstall`=1.
- `rMEMOP_ST`  in  1  store request; held stable by the core while `dstall`=1.
- `rADDR`  in  32  byte address; only [31:2] is used.
- `rDWBSEL`  in  4  byte-lane select (0x1/2/4/8, 0x3/C, 0xF).
- `aexm_dcache_datao`  in  32  store data, already lane-replicated.
- `aexm_dcache_datai`  out  32  load word, registered; unaligned, because the consumer does the sizing.
- `dstall`  out  1  combinational stall to the core.
- `sbuf_empty`  out  1  buffer empty and no write in flight; used for sync/fence.
- `dwb_stb_o`  out  1  bus strobe.
- `dwb_we_o`  out  1  bus write enable.
- `dwb_adr_o`  out  30  bus word address, [31:2].
- `dwb_sel_o`  out  4  bus byte lanes.
- `dwb_dat_o`  out  32  bus write data.
- `dwb_ack_i`  in  1  bus transfer complete.
- `dwb_dat_i`  in  32  bus read data.

## Operation
- **Reset values:** all outputs 0 except `sbuf_empty`=1. Reset clears the FIFO, which discards queued stores, and returns the FSM to IDLE.
- **Stores:**
  - When `dstall`=0, `rMEMOP_ST` enqueues {`rADDR`[31:2], `rDWBSEL`, `aexm_dcache_datao`}.
  - A store asserts `dstall` only when the buffer is full (count==DEPTH). A drain completing in the same cycle does not free the slot for that cycle.
- **Loads:**
  - `dstall` = `rMEMOP_LD` & !`ld_done`. `ld_done` is a one-cycle registered pulse.
  - Hazard: a load hazards when its word address equals the address of any valid entry or of the write in flight. A hazarding load waits until the matching entries drain.
  - A non-hazard load bypasses queued stores.
- **FSM states:** IDLE, WR, RD.
  - IDLE → RD: load pending, no hazard, `ld_done`=0. Load wins over drain.
  - IDLE → WR: FIFO non-empty and no eligible load.
  - WR → IDLE: on `dwb_ack_i`. Pop the head entry.
  - RD → IDLE: on `dwb_ack_i`. Register `dwb_dat_i` into `aexm_dcache_datai` and pulse `ld_done`.
- **Bus rules:**
  - `dwb_stb_o`, `dwb_we_o`, `dwb_adr_o`, `dwb_sel_o` and `dwb_dat_o` are registered and stay stable from strobe rise until the ack edge.
  - `dwb_stb_o` falls on the ack edge and spends at least one cycle low in IDLE.
  - `dwb_ack_i` is ignored while `dwb_stb_o`=0.
- **Simultaneous events:**
  - Enqueue and pop in the same cycle leave the count unchanged.
  - A load and a store never arrive together.
- **Wrap-around:** pointers wrap modulo DEPTH. `sbuf_empty` = (count==0) & state≠WR.

## Timing
- Store accepted at edge N → strobe high at edge N+1 at the earliest, if in IDLE with no load pending.
- Load presented in cycle N in IDLE, no hazard → strobe at edge N+1. With ack sampled at edge M, `aexm_dcache_datai` is valid and `dstall`=0 in cycle M+1. Minimum stall: 2 cycles.
- `aexm_dcache_datai` holds its value until the next load completes.
- Zero-wait bus sustains one store per 2 cycles of drain.

## Configuration
- `AEXM_DWB_SBUF_FWD_EN` **defined:**
  - Applies when a hazarding load's newest matching entry has a `sel` that covers the load's `rDWBSEL`.
  - That entry's data is registered into `aexm_dcache_datai` and `ld_done` pulses one edge after the request, with no bus cycle and a 1-cycle stall.
  - Partial coverage falls back to drain-then-load.
- **Undefined:** every hazard drains first. No CAM data mux is built.

## Structure
- Package `aexm_dwb_pkg` holds:
  - the FSM state enum;
  - the `sbuf_entry_t` struct {adr[29:0], sel[3:0], dat[31:0]};
  - selection encodings.
- Sub-module `aexm_sbuf_fifo`: circular FIFO with per-entry valid bits and address-match outputs: any-hit, and newest-hit index plus data under FWD_EN. The top level contains the FSM, `dstall` and the bus registers.

## Test plan
- **Single store:** store 0xDEADBEEF, sel 0xF, addr 0x100; zero-wait ack. Expect `dwb_stb_o` at edge N+1, adr 0x40, we=1; `sbuf_empty` returns to 1 after ack. No `dstall`.
- **Buffer full:** 5 back-to-back stores, DEPTH=4, ack held low. Expect `dstall` on the 5th. Releasing ack accepts it; the bus sees all 5 in order.
- **Load bypass:** 3 stores to 0x200–0x208, then a load from 0x400 returning 0x12345678. Expect the read strobe before the 2nd store drains and `aexm_dcache_datai`=0x12345678 in cycle ack+1.
- **Load hazard:** store 0xAABBCCDD to 0x300, then load 0x300. Without FWD_EN: read issues only after the write ack, and the bus returns 0xAABBCCDD. With FWD_EN and sel 0xF: no read strobe, data valid after a 1-cycle stall.
- **Partial forward:** store sel 0x1 then load sel 0xF at the same address, with FWD_EN. Expect drain then bus read.
- **Reset mid-operation:** assert `grst` during WR with 2 entries queued. Expect `dwb_stb_o`=0, `sbuf_empty`=1 and `dstall`=0 next cycle; a late ack is ignored.
